// File: rtl/fcmp_pkg.sv
// Shared definitions for the recoded double-precision compare path:
// op encodings, recoded width, canonical NaN and exception flag layout.
package fcmp_pkg;

  localparam int RECF64_W = 65;

  typedef enum logic [2:0] {
    FCMP_FEQ  = 3'd0,
    FCMP_FLT  = 3'd1,
    FCMP_FLE  = 3'd2,
    FCMP_FMIN = 3'd3,
    FCMP_FMAX = 3'd4
  } fcmp_op_e;

  // Recoded canonical quiet NaN: exp top bits 111, sig MSB set.
  localparam logic [RECF64_W-1:0] FCMP_CANON_NAN = 65'h0_E008_0000_0000_0000;

  // Flag bit positions, MSB first: {NV, DZ, OF, UF, NX}.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fcmp_exc_t;

endpackage

// File: rtl/fcmp_core.sv
// Combinational compare of two recoded f64 values (sign, 12-bit exp, 52-bit sig).
module fcmp_core
  import fcmp_pkg::*;
(
  input  logic [RECF64_W-1:0] a,
  input  logic [RECF64_W-1:0] b,
  input  logic                signaling,
  output logic                lt,
  output logic                eq,
  output logic                gt,
  output logic                nv,
  output logic                a_nan,
  output logic                b_nan,
  output logic                both_zero
);

  logic        a_sign, b_sign;
  logic [11:0] a_exp, b_exp;
  logic [51:0] a_sig, b_sig;
  logic        a_zero, b_zero, a_inf, b_inf, a_snan, b_snan;
  logic        both_inf, ordered, lt_mags, eq_mags, ordered_lt, ordered_eq;

  assign {a_sign, a_exp, a_sig} = a;
  assign {b_sign, b_exp, b_sig} = b;

  // Recoded decode: exp[11:9]==0 is zero, exp[11:10]==3 is special, exp[9] picks NaN.
  assign a_zero = (a_exp[11:9] == 3'd0);
  assign b_zero = (b_exp[11:9] == 3'd0);
  assign a_nan  = (a_exp[11:10] == 2'd3) &  a_exp[9];
  assign b_nan  = (b_exp[11:10] == 2'd3) &  b_exp[9];
  assign a_inf  = (a_exp[11:10] == 2'd3) & ~a_exp[9];
  assign b_inf  = (b_exp[11:10] == 2'd3) & ~b_exp[9];
  assign a_snan = a_nan & ~a_sig[51];
  assign b_snan = b_nan & ~b_sig[51];

  assign both_zero = a_zero & b_zero;
  assign both_inf  = a_inf & b_inf;
  assign ordered   = ~a_nan & ~b_nan;

  // The recoded exponent is monotonic in magnitude, so magnitudes compare as {exp, sig}.
  assign lt_mags = (a_exp < b_exp) | ((a_exp == b_exp) & (a_sig < b_sig));
  assign eq_mags = (a_exp == b_exp) & (a_sig == b_sig);

  assign ordered_lt = ~both_zero &
                      ((a_sign & ~b_sign) |
                       (~both_inf & ((a_sign & ~lt_mags & ~eq_mags) | (~b_sign & lt_mags))));
  assign ordered_eq = both_zero | ((a_sign == b_sign) & (both_inf | eq_mags));

  assign lt = ordered & ordered_lt;
  assign eq = ordered & ordered_eq;
  assign gt = ordered & ~ordered_lt & ~ordered_eq;
  assign nv = a_snan | b_snan | (signaling & (a_nan | b_nan));

endmodule

// File: rtl/fcmp_issue_arbiter.sv
// Round-robin arbiter feeding a 2-stage valid/ready compare pipeline that
// returns tagged FEQ/FLT/FLE/FMIN/FMAX results to FP writeback.
module fcmp_issue_arbiter
  import fcmp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           io_req_valid,
  output logic [NUM_REQ-1:0]           io_req_ready,
  input  logic [NUM_REQ*RECF64_W-1:0]  io_req_a,
  input  logic [NUM_REQ*RECF64_W-1:0]  io_req_b,
  input  logic [NUM_REQ*3-1:0]         io_req_op,
  input  logic [NUM_REQ*TAG_W-1:0]     io_req_tag,
  output logic                         io_resp_valid,
  input  logic                         io_resp_ready,
  output logic [1:0]                   io_resp_src,
  output logic [TAG_W-1:0]             io_resp_tag,
  output logic [RECF64_W-1:0]          io_resp_data,
  output logic [4:0]                   io_resp_exc
);

  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic                s1_valid_q, s1_valid_d;
  logic [RECF64_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2:0]          s1_op_q, s1_op_d;
  logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
  logic [1:0]          s1_src_q, s1_src_d;
  logic                s2_valid_q, s2_valid_d;
  logic [RECF64_W-1:0] s2_data_q, s2_data_d;
  fcmp_exc_t           s2_exc_q, s2_exc_d;
  logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;
  logic [1:0]          s2_src_q, s2_src_d;

  logic                grant_found, s1_accept, s1_advance, handshake;
  logic [1:0]          grant;
  logic [RECF64_W-1:0] sel_a, sel_b;
  logic [2:0]          sel_op;
  logic [TAG_W-1:0]    sel_tag;
  logic                signaling, lt, eq, gt, nv, a_nan, b_nan, both_zero, is_min;
  logic [RECF64_W-1:0] res_data;
  fcmp_exc_t           res_exc;

  assign s1_advance = s1_valid_q & (~s2_valid_q | io_resp_ready);
  assign s1_accept  = ~s1_valid_q | s1_advance;
  assign handshake  = grant_found & s1_accept;

  // Round-robin pick: the first valid requester at or after rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant       = rr_ptr_q;
    // Walk the search order backwards so the nearest valid requester wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (io_req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant       = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Route the granted requester's fields and raise its ready.
  always_comb begin
    sel_a        = '0;
    sel_b        = '0;
    sel_op       = '0;
    sel_tag      = '0;
    io_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == 2'(i)) begin
        sel_a           = io_req_a[RECF64_W*i +: RECF64_W];
        sel_b           = io_req_b[RECF64_W*i +: RECF64_W];
        sel_op          = io_req_op[3*i +: 3];
        sel_tag         = io_req_tag[TAG_W*i +: TAG_W];
        io_req_ready[i] = handshake;
      end
    end
  end

  assign signaling = (s1_op_q == FCMP_FLT) | (s1_op_q == FCMP_FLE);
  assign is_min    = (s1_op_q == FCMP_FMIN);

  fcmp_core u_core (
    .a         (s1_a_q),
    .b         (s1_b_q),
    .signaling (signaling),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt),
    .nv        (nv),
    .a_nan     (a_nan),
    .b_nan     (b_nan),
    .both_zero (both_zero)
  );

  // Op decode: select the result value and flags for the s1 operation.
  always_comb begin
    res_data = '0;
    res_exc  = '0;
    case (s1_op_q)
      FCMP_FEQ: begin
        res_data   = {64'b0, eq};
        res_exc.nv = nv;
      end
      FCMP_FLT: begin
        res_data   = {64'b0, lt};
        res_exc.nv = nv;
      end
      FCMP_FLE: begin
        // Ordered and not greater is exactly lt|eq.
        res_data   = {64'b0, ~gt & ~a_nan & ~b_nan};
        res_exc.nv = nv;
      end
      FCMP_FMIN, FCMP_FMAX: begin
        res_exc.nv = nv;
        if (a_nan & b_nan)
          res_data = FCMP_CANON_NAN;
        else if (a_nan)
          res_data = s1_b_q;
        else if (b_nan)
          res_data = s1_a_q;
        else if (both_zero & (s1_a_q[64] ^ s1_b_q[64]))
          res_data = (is_min == s1_a_q[64]) ? s1_a_q : s1_b_q;
        else
          res_data = (is_min == lt) ? s1_a_q : s1_b_q;
      end
      default: res_exc.nv = 1'b1;
    endcase
  end

  // Next state for the pointer and both pipeline stages.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_src_d   = s1_src_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_exc_d   = s2_exc_q;
    s2_tag_d   = s2_tag_q;
    s2_src_d   = s2_src_q;

    if (handshake) begin
      rr_ptr_d   = (grant == 2'(NUM_REQ - 1)) ? 2'd0 : grant + 2'd1;
      s1_valid_d = 1'b1;
      s1_a_d     = sel_a;
      s1_b_d     = sel_b;
      s1_op_d    = sel_op;
      s1_tag_d   = sel_tag;
      s1_src_d   = grant;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    // s2 only changes when it drains or refills, so a stalled result holds still.
    if (s1_advance) begin
      s2_valid_d = 1'b1;
      s2_data_d  = res_data;
      s2_exc_d   = res_exc;
      s2_tag_d   = s1_tag_q;
      s2_src_d   = s1_src_q;
    end else if (io_resp_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: datapath regs are reset too, so response outputs read 0 out of reset.
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s1_src_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_exc_q   <= '0;
      s2_tag_q   <= '0;
      s2_src_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s1_src_q   <= s1_src_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_exc_q   <= s2_exc_d;
      s2_tag_q   <= s2_tag_d;
      s2_src_q   <= s2_src_d;
    end
  end

  assign io_resp_valid = s2_valid_q;
  assign io_resp_data  = s2_data_q;
  assign io_resp_exc   = s2_exc_q;
  assign io_resp_tag   = s2_tag_q;
  assign io_resp_src   = s2_src_q;

endmodule

// File: tb/tb_fcmp_issue_arbiter.sv
// Directed bench for fcmp_issue_arbiter: single ops with hand-computed results,
// round-robin streaming, back-pressure and asynchronous reset.
module tb_fcmp_issue_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 6;

  localparam logic [64:0] ONE   = 65'h0_8000_0000_0000_0000;
  localparam logic [64:0] TWO   = 65'h0_8010_0000_0000_0000;
  localparam logic [64:0] THREE = 65'h0_8018_0000_0000_0000;
  localparam logic [64:0] PZERO = 65'h0_0000_0000_0000_0000;
  localparam logic [64:0] NZERO = 65'h1_0000_0000_0000_0000;
  localparam logic [64:0] QNAN  = 65'h0_E008_0000_0000_0000;
  localparam logic [64:0] SNAN  = 65'h0_E000_0000_0000_0001;
  localparam logic [64:0] CNAN  = 65'h0_E008_0000_0000_0000;

  localparam logic [2:0] OP_FEQ = 3'd0, OP_FLT = 3'd1, OP_FLE = 3'd2,
                         OP_FMIN = 3'd3, OP_FMAX = 3'd4, OP_RSVD = 3'd5;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     io_req_valid;
  logic [NUM_REQ-1:0]     io_req_ready;
  logic [NUM_REQ*65-1:0]  io_req_a, io_req_b;
  logic [NUM_REQ*3-1:0]   io_req_op;
  logic [NUM_REQ*TAG_W-1:0] io_req_tag;
  logic                   io_resp_valid, io_resp_ready;
  logic [1:0]             io_resp_src;
  logic [TAG_W-1:0]       io_resp_tag;
  logic [64:0]            io_resp_data;
  logic [4:0]             io_resp_exc;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  src;
    logic [5:0]  tag;
    logic [64:0] data;
  } exp_t;
  exp_t sb[$];

  fcmp_issue_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (io_req_valid),
    .io_req_ready  (io_req_ready),
    .io_req_a      (io_req_a),
    .io_req_b      (io_req_b),
    .io_req_op     (io_req_op),
    .io_req_tag    (io_req_tag),
    .io_resp_valid (io_resp_valid),
    .io_resp_ready (io_resp_ready),
    .io_resp_src   (io_resp_src),
    .io_resp_tag   (io_resp_tag),
    .io_resp_data  (io_resp_data),
    .io_resp_exc   (io_resp_exc)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    io_req_valid = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // One op from one requester on an empty pipe; response expected exactly two edges later.
  task automatic do_op(input int req, input logic [64:0] a, input logic [64:0] b,
                       input logic [2:0] op, input logic [5:0] tag,
                       input logic [64:0] exp_data, input logic [4:0] exp_exc, input string name);
    io_req_valid                 = '0;
    io_req_valid[req]            = 1'b1;
    io_req_a[65*req +: 65]       = a;
    io_req_b[65*req +: 65]       = b;
    io_req_op[3*req +: 3]        = op;
    io_req_tag[TAG_W*req +: TAG_W] = tag;
    io_resp_ready                = 1'b1;
    @(negedge clock);
    check({name, "_ready"}, 65'(io_req_ready[req]), 65'd1);
    @(posedge clock);
    #1 io_req_valid = '0;
    @(negedge clock);
    check({name, "_lat"}, 65'(io_resp_valid), 65'd0);
    @(posedge clock);
    @(negedge clock);
    check({name, "_valid"}, 65'(io_resp_valid), 65'd1);
    check({name, "_data"}, io_resp_data, exp_data);
    check({name, "_exc"}, 65'(io_resp_exc), 65'(exp_exc));
    check({name, "_src"}, 65'(io_resp_src), 65'(req));
    check({name, "_tag"}, 65'(io_resp_tag), 65'(tag));
    @(posedge clock);
    #1;
  endtask

  // Both requesters stream: req0 FLT(1,2)=1, req1 FMAX(1,3)=3.0; tags {src, count}.
  task automatic run_stream(input int n_valid, input int stall_start, input int stall_len,
                            input int total, input bit final_chk, input bit gap_chk);
    int         n_grant = 0;
    int         n_resp  = 0;
    logic [4:0] cnt [NUM_REQ];
    bit         stalled;
    exp_t       e;
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = '0;
    sb.delete();
    for (int cyc = 0; cyc < total; cyc++) begin
      stalled          = (cyc >= stall_start) && (cyc < stall_start + stall_len);
      io_req_valid     = (cyc < n_valid) ? 2'b11 : 2'b00;
      io_resp_ready    = !stalled;
      io_req_a[64:0]   = ONE;
      io_req_b[64:0]   = TWO;
      io_req_op[2:0]   = OP_FLT;
      io_req_a[129:65] = ONE;
      io_req_b[129:65] = THREE;
      io_req_op[5:3]   = OP_FMAX;
      io_req_tag[5:0]  = {1'b0, cnt[0]};
      io_req_tag[11:6] = {1'b1, cnt[1]};
      @(negedge clock);
      if (stalled) check("stall_ready", 65'(io_req_ready), 65'd0);
      check("one_grant", 65'($countones(io_req_valid & io_req_ready) <= 1), 65'd1);
      if (io_resp_valid) begin
        if (sb.size() == 0) begin
          check("spurious_resp", 65'd1, 65'd0);
        end else begin
          check("sb_src", 65'(io_resp_src), 65'(sb[0].src));
          check("sb_tag", 65'(io_resp_tag), 65'(sb[0].tag));
          check("sb_data", io_resp_data, sb[0].data);
          if (io_resp_ready) begin
            void'(sb.pop_front());
            n_resp++;
          end
        end
      end else if (gap_chk && n_resp > 0 && n_resp < n_valid) begin
        check("no_gap", 65'(io_resp_valid), 65'd1);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (io_req_valid[i] && io_req_ready[i]) begin
          check("rr_order", 65'(i), 65'(n_grant % 2));
          e.src  = 2'(i);
          e.tag  = {i[0], cnt[i]};
          e.data = (i == 0) ? 65'd1 : THREE;
          sb.push_back(e);
          cnt[i]++;
          n_grant++;
        end
      end
      @(posedge clock);
      #1;
    end
    if (final_chk) begin
      check("drained", 65'(sb.size()), 65'd0);
      check("resp_count", 65'(n_resp), 65'(n_grant));
      if (gap_chk) check("grant_count", 65'(n_grant), 65'(n_valid));
      else check("grants_made", 65'(n_grant > 0), 65'd1);
    end
  endtask

  initial begin
    reset         = 1'b1;
    io_req_valid  = '0;
    io_req_a      = '0;
    io_req_b      = '0;
    io_req_op     = '0;
    io_req_tag    = '0;
    io_resp_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_resp_valid", 65'(io_resp_valid), 65'd0);
    check("rst_resp_data", io_resp_data, 65'd0);
    check("rst_resp_exc", 65'(io_resp_exc), 65'd0);
    check("rst_resp_tag", 65'(io_resp_tag), 65'd0);
    check("rst_resp_src", 65'(io_resp_src), 65'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("idle_req_ready", 65'(io_req_ready), 65'd0);
    check("idle_resp_valid", 65'(io_resp_valid), 65'd0);
    @(posedge clock);
    #1;

    do_op(0, ONE,   TWO,   OP_FLT,  6'h01, 65'd1, 5'b00000, "flt_1_2");
    do_op(1, PZERO, NZERO, OP_FEQ,  6'h02, 65'd1, 5'b00000, "feq_pz_nz");
    do_op(0, QNAN,  ONE,   OP_FLT,  6'h03, 65'd0, 5'b10000, "flt_qnan");
    do_op(1, QNAN,  ONE,   OP_FEQ,  6'h04, 65'd0, 5'b00000, "feq_qnan");
    do_op(0, ONE,   SNAN,  OP_FEQ,  6'h05, 65'd0, 5'b10000, "feq_snan");
    do_op(1, QNAN,  THREE, OP_FMIN, 6'h06, THREE, 5'b00000, "fmin_qnan");
    do_op(0, QNAN,  QNAN,  OP_FMAX, 6'h07, CNAN,  5'b00000, "fmax_2nan");
    do_op(1, PZERO, NZERO, OP_FMIN, 6'h08, NZERO, 5'b00000, "fmin_zeros");
    do_op(0, NZERO, PZERO, OP_FMAX, 6'h09, PZERO, 5'b00000, "fmax_zeros");
    do_op(1, TWO,   TWO,   OP_FLE,  6'h0A, 65'd1, 5'b00000, "fle_eq");
    do_op(0, THREE, ONE,   OP_FLE,  6'h0B, 65'd0, 5'b00000, "fle_gt");
    do_op(1, ONE,   THREE, OP_FMAX, 6'h0C, THREE, 5'b00000, "fmax_1_3");
    do_op(0, SNAN,  ONE,   OP_FMIN, 6'h0D, ONE,   5'b10000, "fmin_snan");
    do_op(1, ONE,   TWO,   OP_RSVD, 6'h0E, 65'd0, 5'b10000, "rsvd_op");

    apply_reset();
    run_stream(8, 1000, 0, 12, 1'b1, 1'b1);

    apply_reset();
    run_stream(12, 4, 5, 20, 1'b1, 1'b0);

    // Leave ops in flight with rr_ptr pointing at req1, then reset mid-cycle.
    apply_reset();
    run_stream(3, 1000, 0, 3, 1'b0, 1'b0);
    check("pre_rst_valid", 65'(io_resp_valid), 65'd1);
    #2 reset = 1'b1;
    #1 check("async_rst_valid", 65'(io_resp_valid), 65'd0);
    io_req_valid = '0;
    sb.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_rst_empty", 65'(io_resp_valid), 65'd0);
    @(posedge clock);
    #1 io_req_valid = 2'b11;
    #1 check("first_grant", 65'(io_req_ready), 65'd1);
    @(posedge clock);
    #1 io_req_valid = '0;
    @(negedge clock);
    check("post_rst_lat", 65'(io_resp_valid), 65'd0);
    @(posedge clock);
    @(negedge clock);
    check("post_rst_valid", 65'(io_resp_valid), 65'd1);
    check("post_rst_src", 65'(io_resp_src), 65'd0);
    check("post_rst_data", io_resp_data, 65'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fcmp_issue_arbiter.md
Name: fcmp_issue_arbiter

Overview:
- Shares one 65-bit recoded double-precision compare datapath between NUM_REQ requesters (e.g. FP issue slots, the FCLASS/FMIN-FMAX path).
- Round-robin arbitration, a 2-stage valid/ready pipeline, and op decode (FEQ/FLT/FLE/FMIN/FMAX).
- Returns a tagged result plus exception flags to the FP writeback path.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TAG_W, 6, width of the opaque tag passed through with each op.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- io_req_valid  in  NUM_REQ  per-requester request valid.
- io_req_ready  out  NUM_REQ  per-requester grant; handshake when valid&ready.
- io_req_a  in  NUM_REQ*65  operand A per requester, recoded format; slice i = [65*i+64:65*i].
- io_req_b  in  NUM_REQ*65  operand B, same packing.
- io_req_op  in  NUM_REQ*3  op per requester: 0 FEQ, 1 FLT, 2 FLE, 3 FMIN, 4 FMAX; 5-7 reserved.
- io_req_tag  in  NUM_REQ*TAG_W  tag per requester.
- io_resp_valid  out  1  result valid.
- io_resp_ready  in  1  writeback accepts.
- io_resp_src  out  2  index of the originating requester.
- io_resp_tag  out  TAG_W  tag echoed from the request.
- io_resp_data  out  65  result: {64'b0, bit} for FEQ/FLT/FLE; recoded value for FMIN/FMAX.
- io_resp_exc  out  5  flags {NV,DZ,OF,UF,NX}; only NV is ever set.

Behaviour:
- Reset: s1_valid=0, s2_valid=0, rr_ptr=0.
  - All outputs 0 except io_req_ready, which follows from the empty pipe.
  - Reset asserted mid-operation discards in-flight ops with no response.
- Arbitration:
  - Round-robin starting at rr_ptr.
  - io_req_ready[i]=1 only for the granted index, and only when s1 can accept: !s1_valid | s1_advance.
  - At most one grant per cycle.
  - On a handshake, rr_ptr <= grant+1 mod NUM_REQ; otherwise rr_ptr holds.
- Stage 1 register: a, b, op, tag, src.
  - s1_advance = s1_valid & (!s2_valid | io_resp_ready).
- Stage 2:
  - Compare is combinational on the s1 operands.
  - signaling = 1 for FLT/FLE, 0 otherwise.
  - Result and flags are registered into s2.
  - The s2 content is held stable while io_resp_valid & !io_resp_ready.
- Latency: request handshake in cycle N -> io_resp_valid in cycle N+2 when not stalled.
- Throughput: 1 op per cycle.
- Simultaneous s2 drain and s1 advance in the same cycle is legal and keeps the pipe full.
- Compare outputs are lt/eq/gt/NV:
  - NaN on either side gives unordered: lt=eq=gt=0.
  - NV is set for any sNaN (NaN with sig bit 51 == 0).
  - NV is also set for any NaN when signaling=1.
  - +0 and -0 are equal.
- Results:
  - FEQ: eq.
  - FLT: lt.
  - FLE: lt|eq.
  - FMIN/FMAX when both operands are NaN: canonical NaN 65'h0_E008_0000_0000_0000.
  - FMIN/FMAX when exactly one operand is NaN: the other operand.
  - FMIN/FMAX when both are zero of opposite sign: FMIN returns -0, FMAX returns +0.
  - Otherwise FMIN returns lt ? a : b, and FMAX returns lt ? b : a.
- Reserved op: result 0, io_resp_exc = 5'b10000.

Decomposition:
- Shared package fcmp_pkg:
  - op encodings: FCMP_FEQ..FCMP_FMAX.
  - RECF64_W=65.
  - canonical recoded NaN constant.
  - flag bit positions.
- Sub-module fcmp_core: purely combinational.
  - Inputs: a, b, signaling.
  - Outputs: lt, eq, gt, nv, a_nan, b_nan, both_zero.
  - Holds the recoded-field decode (exp[11:9]==0 means zero; exp[11:10]==3 means special; exp[9] distinguishes NaN/inf).
- Arbiter, pipeline registers and result mux live in fcmp_issue_arbiter.

Test Plan:
- FLT from req0: a=1.0, b=2.0 (recoded) -> resp 2 cycles later: data=1, exc=0, src=0, tag echoed.
- FEQ from req1: a=+0, b=-0 -> data=1, exc=0.
- FLT with a=qNaN -> data=0, exc=5'b10000.
- FEQ with a=qNaN -> data=0, exc=0.
- FEQ with b=sNaN -> data=0, exc=5'b10000.
- FMIN: a=qNaN, b=3.0 -> data=3.0.
- FMAX: both qNaN -> data=65'h0_E008_0000_0000_0000.
- FMIN(+0,-0) -> -0.
- Both requesters valid continuously for 8 cycles with io_resp_ready=1 -> grants alternate 0,1,0,1.
  - 8 responses arrive in order with matching src/tag.
  - No gaps after the first response.
- io_resp_ready low for 5 cycles with both requesters streaming:
  - s2 holds its data stable.
  - s1 fills, then io_req_ready drops to 0.
  - No op is lost or duplicated after ready returns.
- Assert reset with both stages valid:
  - io_resp_valid is 0 immediately (asynchronous).
  - After release the pipe is empty, rr_ptr=0, and the first grant goes to req0.
